// File: rtl/prog_pkg.sv
// Shared types and configuration-word layout for the SPI programming master.
// prog_word is built from the field offsets and widths below.
`timescale 1ns/1ps
package prog_pkg;

  localparam int NUM_BITS = 104;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    LATCH,
    DRST,
    DRST_REC
  } prog_state_t;

  // Layout of the configuration word; bit 0 is the first bit on the wire.
  localparam int GTHDR_OFF       = 0;
  localparam int GTHDR_W         = 4;
  localparam int ATHHI_OFF       = 4;
  localparam int ATHHI_W         = 9;
  localparam int ATHLO_OFF       = 13;
  localparam int ATHLO_W         = 9;
  localparam int DLL_DAC_OFF     = 22;
  localparam int DLL_DAC_W       = 5;
  localparam int BIAS_TRIM_OFF   = 27;
  localparam int BIAS_TRIM_W     = 8;
  localparam int CH_MASK_OFF     = 35;
  localparam int CH_MASK_W       = 64;
  localparam int TEST_SEL_OFF    = 99;
  localparam int TEST_SEL_W      = 4;
  localparam int CLK_OUT_SEL_OFF = 103;
  localparam int CLK_OUT_SEL_W   = 1;

  function automatic logic [NUM_BITS-1:0] set_field(
    input logic [NUM_BITS-1:0] word,
    input int                  off,
    input int                  width,
    input logic [NUM_BITS-1:0] value
  );
    logic [NUM_BITS-1:0] mask;
    mask = ({NUM_BITS{1'b1}} >> (NUM_BITS - width)) << off;
    return (word & ~mask) | ((value << off) & mask);
  endfunction

endpackage

// File: rtl/prog_tick_div.sv
// Half-period divider: one-cycle tick every CLK_DIV clocks.
// restart realigns the count so each state lasts exactly CLK_DIV cycles.
`timescale 1ns/1ps
module prog_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/prog_spi_master.sv
// Mode-00 SPI frame generator for the configuration shift register, LSB first.
// Optional digital-reset pulse (SCLK high with CS high) enabled by PROG_DRESET_EN.
`timescale 1ns/1ps
module prog_spi_master #(
  parameter int NUM_BITS      = prog_pkg::NUM_BITS,
  parameter int CLK_DIV       = 4
`ifdef PROG_DRESET_EN
  ,
  parameter int DRESET_CYCLES = 8
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] prog_word,
`ifdef PROG_DRESET_EN
  input  logic                dreset_req,
`endif
  output logic                busy,
  output logic                done,
  output logic                SDI,
  output logic                SCLK,
  output logic                CS
);

  import prog_pkg::*;

  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS);

  prog_state_t         state;
  prog_state_t         next_state;
  logic [NUM_BITS-1:0] shadow;
  logic [BW-1:0]       bit_cnt;
  logic                tick;
  logic                restart;
  logic                sdi_next;
  logic                sclk_next;
  logic                cs_next;

`ifdef PROG_DRESET_EN
  localparam int DW = $clog2(DRESET_CYCLES + 1);
  logic [DW-1:0] drst_cnt;
  logic          drst_last;

  always_ff @(posedge clk) begin
    if (reset || state != DRST) begin
      drst_cnt <= '0;
    end else begin
      drst_cnt <= drst_cnt + 1'b1;
    end
  end

  assign drst_last = (drst_cnt == DW'(DRESET_CYCLES - 1));
`endif

  assign restart = (state == IDLE) || (next_state != state);

  prog_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SETUP;
        end
`ifdef PROG_DRESET_EN
        else if (dreset_req) begin
          next_state = DRST;
        end
`endif
      end
      SETUP:    if (tick) next_state = HIGH;
      HIGH:     if (tick) next_state = (bit_cnt == LAST_BIT) ? HOLD : LOW;
      LOW:      if (tick) next_state = HIGH;
      HOLD:     if (tick) next_state = LATCH;
      LATCH:    if (tick) next_state = IDLE;
`ifdef PROG_DRESET_EN
      DRST:     if (drst_last) next_state = DRST_REC;
      DRST_REC: if (tick) next_state = IDLE;
`else
      DRST:     next_state = IDLE;
      DRST_REC: next_state = IDLE;
`endif
      default:  next_state = IDLE;
    endcase
  end

  // Pin values are decoded from next_state and registered, so CS/SCLK/SDI are pure flops.
  always_comb begin
    sdi_next  = 1'b0;
    sclk_next = 1'b0;
    cs_next   = 1'b0;
    case (next_state)
      IDLE:     cs_next = 1'b1;
      SETUP:    sdi_next = (state == IDLE) ? prog_word[0] : SDI;
      HIGH: begin
        sclk_next = 1'b1;
        sdi_next  = SDI;
      end
      LOW:      sdi_next = (state == HIGH) ? shadow[0] : SDI;
      HOLD:     sdi_next = 1'b0;
      LATCH:    cs_next = 1'b1;
      DRST: begin
        cs_next   = 1'b1;
        sclk_next = 1'b1;
      end
      DRST_REC: cs_next = 1'b1;
      default:  cs_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      SDI     <= 1'b0;
      SCLK    <= 1'b0;
      CS      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= next_state;
      SDI   <= sdi_next;
      SCLK  <= sclk_next;
      CS    <= cs_next;
      busy  <= (next_state != IDLE);
      done  <= (next_state == IDLE) && (state == LATCH || state == DRST_REC);
      // shadow holds the bits not yet driven; bit 0 goes straight to SDI at accept.
      if (state == IDLE && next_state == SETUP) begin
        shadow  <= {1'b0, prog_word[NUM_BITS-1:1]};
        bit_cnt <= '0;
      end else begin
        if (state == HIGH && next_state == LOW) begin
          shadow <= shadow >> 1;
        end
        if (next_state == HIGH && state != HIGH) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_spi_master.sv
// Self-checking bench for prog_spi_master with four instances (CLK_DIV 2,1,3,4).
// A downstream shift-register model latches the word on each CS rising edge.
`timescale 1ns/1ps
module tb_prog_spi_master;
  import prog_pkg::*;

  localparam int NDUT = 4;
  localparam int DIVS [NDUT] = '{2, 1, 3, 4};
  localparam int NB = NUM_BITS;

  logic clk = 1'b0;
  logic reset;
  logic [NDUT-1:0] start;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;
  logic [NDUT-1:0] sdi;
  logic [NDUT-1:0] sclk;
  logic [NDUT-1:0] cs;
  logic [NB-1:0]   word [NDUT];
`ifdef PROG_DRESET_EN
  logic [NDUT-1:0] dreset_req;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    prog_spi_master #(.NUM_BITS(NB), .CLK_DIV(DIVS[g])) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start[g]),
      .prog_word  (word[g]),
`ifdef PROG_DRESET_EN
      .dreset_req (dreset_req[g]),
`endif
      .busy       (busy[g]),
      .done       (done[g]),
      .SDI        (sdi[g]),
      .SCLK       (sclk[g]),
      .CS         (cs[g])
    );
  end

  // Downstream register model plus pin-protocol monitors, sampled on the falling edge.
  logic [NB-1:0]   shreg   [NDUT];
  logic [NB-1:0]   latched [NDUT];
  logic [NDUT-1:0] p_sclk = '0;
  logic [NDUT-1:0] p_sdi  = '0;
  logic [NDUT-1:0] p_cs   = '1;
  int rises     [NDUT];
  int low_run   [NDUT];
  int high_run  [NDUT];
  int last_low  [NDUT];
  int last_high [NDUT];
  int inv_err   [NDUT];
  int setup_err [NDUT];
  int hold_err  [NDUT];
  int sdi_age   [NDUT];
  int rise_age  [NDUT];
  int done_cnt  [NDUT];

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      automatic logic rise = sclk[g] && !p_sclk[g];
      automatic logic chg  = (sdi[g] != p_sdi[g]);
      automatic int   s_age = chg ? 0 : sdi_age[g] + 1;
      automatic int   r_age = rise ? 0 : rise_age[g] + 1;
      automatic logic bad;
`ifdef PROG_DRESET_EN
      bad = cs[g] && sdi[g];
`else
      bad = cs[g] && (sdi[g] || sclk[g]);
`endif
      sdi_age[g]  <= s_age;
      rise_age[g] <= r_age;
      p_sclk[g]   <= sclk[g];
      p_sdi[g]    <= sdi[g];
      p_cs[g]     <= cs[g];
      if (bad) inv_err[g] <= inv_err[g] + 1;
      if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
      if (chg && !cs[g] && r_age < DIVS[g]) hold_err[g] <= hold_err[g] + 1;
      if (reset) begin
        shreg[g]   <= '0;
        latched[g] <= '0;
      end else begin
        if (rise && !cs[g]) begin
          rises[g] <= rises[g] + 1;
          shreg[g] <= {sdi[g], shreg[g][NB-1:1]};
          if (s_age < DIVS[g]) setup_err[g] <= setup_err[g] + 1;
        end
        if (cs[g] && !p_cs[g]) latched[g] <= shreg[g];
      end
      if (cs[g]) begin
        high_run[g] <= p_cs[g] ? high_run[g] + 1 : 1;
        if (!p_cs[g]) last_low[g] <= low_run[g];
      end else begin
        low_run[g] <= p_cs[g] ? 1 : low_run[g] + 1;
        if (p_cs[g]) last_high[g] <= high_run[g];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [NB-1:0] actual,
                             input logic [NB-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One frame on instance g; done_at counts cycles from the accept cycle t0.
  task automatic applyStimulus(input int g, input logic [NB-1:0] w,
                               output int done_at, output int rise_cnt);
    int base;
    int n;
    @(posedge clk); #1;
    start[g] = 1'b1;
    word[g]  = w;
    base     = rises[g];
    @(posedge clk); #1;
    start[g] = 1'b0;
    n        = 1;
    done_at  = -1;
    while (n < 5000) begin
      @(negedge clk);
      if (done[g]) begin
        done_at = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    rise_cnt = rises[g] - base;
  endtask

  function automatic logic [NB-1:0] rand_word();
    logic [NB-1:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w = (w << 32) | NB'($urandom);
    return w;
  endfunction

  typedef struct {
    int            g;
    logic [NB-1:0] w;
    int            exp_low;
    int            exp_done;
  } vec_t;

  vec_t          vecs [4];
  logic [NB-1:0] w_main;
  logic [NB-1:0] w_exp;
  logic [NB-1:0] w_c;
  int            done_at;
  int            rise_cnt;
  int            n;
  int            k;
  int            d0;
  int            base;
  int            hi;
  int            times [3];

  initial begin
    reset = 1'b1;
    start = '0;
    for (int g = 0; g < NDUT; g++) word[g] = '0;
`ifdef PROG_DRESET_EN
    dreset_req = '0;
`endif

    w_main = set_field('0, GTHDR_OFF, GTHDR_W, NB'(4'hA));
    w_main = set_field(w_main, ATHHI_OFF, ATHHI_W, NB'(9'h155));
    w_main = set_field(w_main, DLL_DAC_OFF, DLL_DAC_W, NB'(5'h13));
    w_exp  = NB'(32'h04C0_155A);

    vecs[0] = '{g: 0, w: w_main,      exp_low: 418, exp_done: 421};
    vecs[1] = '{g: 1, w: rand_word(), exp_low: 209, exp_done: 211};
    vecs[2] = '{g: 2, w: rand_word(), exp_low: 627, exp_done: 631};
    vecs[3] = '{g: 3, w: rand_word(), exp_low: 836, exp_done: 841};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("reset_cs%0d", g), NB'(cs[g]), NB'(1));
      checkOutput($sformatf("reset_busy%0d", g), NB'(busy[g]), NB'(0));
    end
    checkOutput("reset_sclk", NB'(sclk[0]), NB'(0));
    checkOutput("reset_sdi", NB'(sdi[0]), NB'(0));
    checkOutput("reset_done", NB'(done[0]), NB'(0));
    #1 reset = 1'b0;

    checkOutput("field_pack", w_main, w_exp);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].g, vecs[i].w, done_at, rise_cnt);
      checkOutput($sformatf("v%0d_done_at", i), NB'(done_at), NB'(vecs[i].exp_done));
      checkOutput($sformatf("v%0d_cs_low", i), NB'(last_low[vecs[i].g]), NB'(vecs[i].exp_low));
      checkOutput($sformatf("v%0d_rises", i), NB'(rise_cnt), NB'(NB));
      checkOutput($sformatf("v%0d_latched", i), latched[vecs[i].g], vecs[i].w);
    end

    $display("[TB] start while busy and prog_word change after accept");
    d0 = done_cnt[0];
    @(posedge clk); #1;
    start[0] = 1'b1;
    word[0]  = w_main;
    done_at  = -1;
    for (n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      start[0] = (n == 50);
      if (n == 60) word[0] = ~w_main;
      @(negedge clk);
      if (done[0] && done_at < 0) done_at = n;
    end
    checkOutput("ignore_done_at", NB'(done_at), NB'(421));
    checkOutput("ignore_done_cnt", NB'(done_cnt[0] - d0), NB'(1));
    checkOutput("ignore_busy", NB'(busy[0]), NB'(0));
    checkOutput("ignore_latched", latched[0], w_main);

    $display("[TB] reset after the 50th SCLK rise");
    w_c = rand_word();
    d0  = done_cnt[0];
    @(posedge clk); #1;
    start[0] = 1'b1;
    word[0]  = w_c;
    base     = rises[0];
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    while (rises[0] - base < 50 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("abort_rises", NB'(rises[0] - base), NB'(50));
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_cs", NB'(cs[0]), NB'(1));
    checkOutput("abort_sclk", NB'(sclk[0]), NB'(0));
    checkOutput("abort_sdi", NB'(sdi[0]), NB'(0));
    checkOutput("abort_busy", NB'(busy[0]), NB'(0));
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    checkOutput("abort_no_done", NB'(done_cnt[0] - d0), NB'(0));
    applyStimulus(0, w_c, done_at, rise_cnt);
    checkOutput("after_abort_done_at", NB'(done_at), NB'(421));
    checkOutput("after_abort_latched", latched[0], w_c);

    $display("[TB] start held for three frames, CLK_DIV=1");
    times = '{0, 0, 0};
    word[1] = vecs[1].w;
    d0 = done_cnt[1];
    @(posedge clk); #1;
    start[1] = 1'b1;
    n = 0;
    k = 0;
    while (k < 3 && n < 2000) begin
      @(negedge clk);
      if (done[1]) begin
        times[k] = n;
        k++;
        if (k == 3) start[1] = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    checkOutput("b2b_first", NB'(times[0]), NB'(211));
    checkOutput("b2b_gap1", NB'(times[1] - times[0]), NB'(211));
    checkOutput("b2b_gap2", NB'(times[2] - times[1]), NB'(211));
    checkOutput("b2b_cs_high", NB'(last_high[1]), NB'(2));
    checkOutput("b2b_latched", latched[1], vecs[1].w);
    repeat (10) @(posedge clk);
    checkOutput("b2b_done_cnt", NB'(done_cnt[1] - d0), NB'(3));
    @(negedge clk);
    checkOutput("b2b_idle", NB'(busy[1]), NB'(0));

`ifdef PROG_DRESET_EN
    $display("[TB] digital-reset pulse");
    @(posedge clk); #1;
    dreset_req[1] = 1'b1;
    @(posedge clk); #1;
    dreset_req[1] = 1'b0;
    hi = 0;
    done_at = -1;
    for (n = 1; n < 40; n++) begin
      @(negedge clk);
      if (sclk[1] && cs[1]) hi++;
      if (done[1] && done_at < 0) done_at = n;
      @(posedge clk); #1;
    end
    checkOutput("drst_sclk_high", NB'(hi), NB'(8));
    checkOutput("drst_done_at", NB'(done_at), NB'(10));

    @(posedge clk); #1;
    dreset_req[1] = 1'b1;
    start[1]      = 1'b1;
    @(posedge clk); #1;
    dreset_req[1] = 1'b0;
    start[1]      = 1'b0;
    hi = 0;
    done_at = -1;
    for (n = 1; n < 260; n++) begin
      @(negedge clk);
      if (sclk[1] && cs[1]) hi++;
      if (done[1] && done_at < 0) done_at = n;
      @(posedge clk); #1;
    end
    checkOutput("prio_no_drst", NB'(hi), NB'(0));
    checkOutput("prio_done_at", NB'(done_at), NB'(211));
`endif

    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("cs_invariant%0d", g), NB'(inv_err[g]), NB'(0));
      checkOutput($sformatf("sdi_setup%0d", g), NB'(setup_err[g]), NB'(0));
      checkOutput($sformatf("sdi_hold%0d", g), NB'(hold_err[g]), NB'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
